// File: rtl/aes_ctr_pkg.sv
// Shared definitions for the AES CTR keystream path: block geometry and
// the sequencer state encoding.
package aes_ctr_pkg;

  localparam int BLOCK_W = 128;
  localparam int NONCE_W = 96;
  localparam int CTR_W   = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    CAPTURE   = 3'd4,
    DRAIN     = 3'd5
  } ctr_state_t;

endpackage

// File: rtl/aes_ctr_block_fifo.sv
// Synchronous 128-bit block FIFO with occupancy count. Head data is
// presented combinationally on rd_data; only pointers/count are reset.
module aes_ctr_block_fifo
  import aes_ctr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [BLOCK_W-1:0]       wr_data,
  input  logic                     rd_en,
  output logic [BLOCK_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count_r;
  logic               do_wr;
  logic               do_rd;

  assign full    = (count_r == (AW+1)'(DEPTH));
  assign empty   = (count_r == '0);
  assign count   = count_r;
  assign rd_data = mem[rd_ptr];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/aes_ctr_stream.sv
// CTR-mode sequencer and keystream serialiser behind the AES round engine.
// Define AES_CTR_STREAM_BSWAP_EN to byte-reverse every output word.
module aes_ctr_stream
  import aes_ctr_pkg::*;
#(
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [CTR_W-1:0]   ctr_init,
  input  logic [CNT_W-1:0]   num_blocks,
  output logic               busy,
  output logic               done,
  output logic               core_next,
  output logic [BLOCK_W-1:0] core_block,
  input  logic               core_ready,
  input  logic [BLOCK_W-1:0] core_result,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data,
  input  logic               out_ready
);

  localparam int WORDS  = BLOCK_W / OUT_W;
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [OUT_W-1:0] byte_rev(input logic [OUT_W-1:0] w);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_W / 8; i++)
      r[i*8 +: 8] = w[OUT_W-8-i*8 +: 8];
    return r;
  endfunction

  ctr_state_t         state, state_nx;
  logic [NONCE_W-1:0] nonce_r;
  logic [CTR_W-1:0]   ctr_r;
  logic [CNT_W-1:0]   remaining_r;
  logic               zero_done_r;
  logic               start_acc;
  logic               in_flight;
  logic               can_issue;
  logic               fifo_wr;
  logic               fifo_pop;
  logic [BLOCK_W-1:0] fifo_head;
  logic [FCNT_W-1:0]  fifo_count;
  logic [FCNT_W-1:0]  free_slots;
  logic               fifo_full;
  logic               fifo_empty;
  logic [IDX_W-1:0]   word_idx_r;
  logic               last_word;
  logic               word_fire;
  logic [OUT_W-1:0]   word_sel;

  assign start_acc  = start && (state == IDLE);
  assign in_flight  = (state == WAIT_ACK) || (state == WAIT_DONE) || (state == CAPTURE);
  assign free_slots = FCNT_W'(FIFO_DEPTH) - fifo_count;
  assign can_issue  = !fifo_full && (free_slots > FCNT_W'(in_flight));
  assign busy       = (state != IDLE);
  assign done       = zero_done_r || ((state == DRAIN) && fifo_empty);
  assign core_block = {nonce_r, ctr_r};

  // Sequencer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      nonce_r     <= '0;
      ctr_r       <= '0;
      remaining_r <= '0;
      zero_done_r <= 1'b0;
    end else begin
      state       <= state_nx;
      zero_done_r <= start_acc && (num_blocks == '0);
      if (start_acc && (num_blocks != '0)) begin
        nonce_r     <= nonce;
        ctr_r       <= ctr_init;
        remaining_r <= num_blocks;
      end else if (state == CAPTURE) begin
        ctr_r       <= ctr_r + CTR_W'(1);
        remaining_r <= remaining_r - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    core_next = 1'b0;
    fifo_wr   = 1'b0;
    case (state)
      IDLE:      if (start && (num_blocks != '0)) state_nx = ISSUE;
      ISSUE: begin
        if (can_issue) begin
          core_next = 1'b1;
          state_nx  = WAIT_ACK;
        end
      end
      // First engine pulse is the accept, second marks the final round
      WAIT_ACK:  if (core_ready) state_nx = WAIT_DONE;
      WAIT_DONE: if (core_ready) state_nx = CAPTURE;
      CAPTURE: begin
        fifo_wr  = 1'b1;
        state_nx = (remaining_r == CNT_W'(1)) ? DRAIN : ISSUE;
      end
      DRAIN:     if (fifo_empty) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  aes_ctr_block_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (core_result),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Serialiser walks the FIFO head in place; the block pops with its last word
  assign out_valid = !fifo_empty;
  assign last_word = (word_idx_r == IDX_W'(WORDS - 1));
  assign word_fire = out_valid && out_ready;
  assign fifo_pop  = word_fire && last_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_idx_r <= '0;
    end else if (word_fire) begin
      word_idx_r <= last_word ? '0 : word_idx_r + 1'b1;
    end
  end

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < WORDS; i++)
      if (word_idx_r == IDX_W'(i)) word_sel = fifo_head[BLOCK_W-1-i*OUT_W -: OUT_W];
  end

`ifdef AES_CTR_STREAM_BSWAP_EN
  assign out_data = out_valid ? byte_rev(word_sel) : '0;
`else
  assign out_data = out_valid ? word_sel : '0;
`endif

endmodule
